// File: rtl/scoreboard_fifo.sv
// rtl/scoreboard_fifo.sv - expected-result FIFO scoreboard with saturating statistics
// Optional first-mismatch capture (first_idx/first_act/first_exp) enabled by `define SCB_FIRST_ERR_EN.
module scoreboard_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       exp_data,
  input  logic                    exp_valid,
  output logic                    exp_ready,
  input  logic [DATA_W-1:0]       act_data,
  input  logic                    act_valid,
  input  logic                    clear,
  output logic [CNT_W-1:0]        total,
  output logic [CNT_W-1:0]        correct,
  output logic [CNT_W-1:0]        underflow_cnt,
  output logic [DATA_W-1:0]       err_act,
  output logic [DATA_W-1:0]       err_exp,
  output logic [$clog2(DEPTH):0]  level,
`ifdef SCB_FIRST_ERR_EN
  output logic [CNT_W-1:0]        first_idx,
  output logic [DATA_W-1:0]       first_act,
  output logic [DATA_W-1:0]       first_exp,
`endif
  output logic                    mismatch
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;

  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_correct;
  logic [CNT_W-1:0]  r_underflow;
  logic [DATA_W-1:0] r_err_act;
  logic [DATA_W-1:0] r_err_exp;
  logic              r_mismatch;
`ifdef SCB_FIRST_ERR_EN
  logic [CNT_W-1:0]  r_first_idx;
  logic [DATA_W-1:0] r_first_act;
  logic [DATA_W-1:0] r_first_exp;
`endif

  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // A push into an empty FIFO is not visible to an act in the same cycle: that act is an underflow.
  assign w_empty   = (r_level == '0);
  assign exp_ready = (r_level < FULL_LVL);
  assign w_push    = exp_valid && exp_ready && !rst;
  assign w_pop     = act_valid && !w_empty && !rst;
  assign w_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // clear only touches statistics; the FIFO block above keeps popping regardless.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_total     <= '0;
      r_correct   <= '0;
      r_underflow <= '0;
      r_err_act   <= '0;
      r_err_exp   <= '0;
      r_mismatch  <= 1'b0;
`ifdef SCB_FIRST_ERR_EN
      r_first_idx <= '0;
      r_first_act <= '0;
      r_first_exp <= '0;
`endif
    end else if (act_valid) begin
      r_total <= sat_inc(r_total);
      if (w_empty) begin
        r_underflow <= sat_inc(r_underflow);
      end else if (act_data == w_head) begin
        r_correct <= sat_inc(r_correct);
      end else begin
        r_err_act  <= act_data;
        r_err_exp  <= w_head;
        r_mismatch <= 1'b1;
`ifdef SCB_FIRST_ERR_EN
        if (!r_mismatch) begin
          r_first_idx <= r_total;
          r_first_act <= act_data;
          r_first_exp <= w_head;
        end
`endif
      end
    end
  end

  assign total         = r_total;
  assign correct       = r_correct;
  assign underflow_cnt = r_underflow;
  assign err_act       = r_err_act;
  assign err_exp       = r_err_exp;
  assign mismatch      = r_mismatch;
  assign level         = r_level;
`ifdef SCB_FIRST_ERR_EN
  assign first_idx     = r_first_idx;
  assign first_act     = r_first_act;
  assign first_exp     = r_first_exp;
`endif

endmodule
